dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Sequences and shares the single-port 64x32 data memory between two requesters.
- Port 0 is the pipeline MEM stage; port 1 is the debug/display/console loader.
- Drives the memory's ra/D/load/str/sel controls and returns read data with a one-cycle ack pulse.
- Fixed priority to port 0, with a starvation guard that forces a port 1 grant after MAX_WAIT consecutive port 0 grants while port 1 waits.

Parameters:
- AW, 6, memory address width (64 words)
- DW, 32, data width
- MAX_WAIT, 4, max consecutive port 0 grants while port 1 is requesting (range 1..15)

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- p0_req  in  1  port 0 access request; held until p0_ack
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  AW  port 0 word address
- p0_wdata  in  DW  port 0 write data
- p0_ack  out  1  one-cycle completion pulse
- p0_rdata  out  DW  read data, valid while p0_ack=1
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
- p0_stall  out  1  port 0 requesting but not yet acked (pipeline freeze)
- dm_ra  out  AW  memory address
- dm_rb  out  AW  memory second read address; always equals dm_ra
- dm_D  out  DW  memory write data
- dm_load  out  1  memory read strobe
- dm_str  out  1  memory write strobe
- dm_sel  out  1  memory select
- dm_A_out  in  DW  memory read data (combinational from ra)

Behaviour:
- Reset values: state=IDLE; all outputs 0; wait_cnt=0; latched fields 0.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Winner selection: port 1 if p1_req and (not p0_req or wait_cnt==MAX_WAIT); else port 0 if p0_req.
  - On a winner: register owner, we, addr, wdata, then go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Drive dm_sel=1, dm_ra=addr, dm_D=wdata; dm_str=we, dm_load=~we.
  - On a read, capture dm_A_out into the owner's rdata register at the clock edge. A write commits in the memory at the same edge.
  - Go to ACK.
- ACK (exactly 1 cycle):
  - Owner's ack=1; rdata holds the read value (write: rdata unchanged).
  - All dm_* controls are 0.
  - Always return to IDLE. The requester must drop req in the cycle after ack, or present a new request.
- Latency: request seen in IDLE at cycle N, ACCESS at N+1, ack at N+2. Max throughput is one access per 3 cycles.
- dm_* outputs are combinational from state and registered fields. They are 0 in IDLE and ACK.
- wait_cnt:
  - Increments when port 0 is granted while p1_req=1, saturating at MAX_WAIT.
  - Clears to 0 when port 1 is granted.
  - Clears to 0 when port 0 is granted with p1_req=0.
- p0_stall = p0_req & ~p0_ack, combinational.
- Request fields are sampled only at the IDLE grant. Changes to them afterwards are ignored until the next grant.
- Simultaneous requests with wait_cnt<MAX_WAIT: port 0 wins. Port 1 keeps waiting and its req is not consumed.
- A req deasserted before grant is dropped silently; no ack is produced.
- clr at any time returns to IDLE, clears acks and wait_cnt, and deasserts all dm_* controls. An in-flight write is aborted (the memory is also cleared by clr). No ack is issued for the aborted access.
- Back-to-back same address, write then read: the read sees the new value, since the write committed in an earlier ACCESS.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_p0_grants[15:0], stat_p1_grants[15:0] and stat_conflicts[15:0].
  - Each counter increments on its event and wraps modulo 2^16. A conflict is an IDLE grant with both reqs high.
  - All counters clear on clr.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dm_arb_pkg holds:
  - The state enum (IDLE, ACCESS, ACK).
  - Owner encoding (OWN_P0=0, OWN_P1=1).
  - DM_AW=6 and DM_DW=32 constants.
- One sub-module, dm_arb_prio, is natural: combinational winner selection plus the wait_cnt register. The top holds the FSM, latches and the memory interface.

Test Plan:
- Single read: after reset, memory word 5 is preloaded with 0xDEADBEEF via a port 1 write. Then p0 reads address 5 → dm_load=1 and dm_ra=5 at N+1, p0_ack=1 with p0_rdata=0xDEADBEEF at N+2.
- Write/readback: p1 writes 0x12345678 to address 63, then p1 reads 63 → the read returns 0x12345678. dm_str=1 for exactly one cycle.
- Contention: p0 and p1 both request continuously, MAX_WAIT=4 → grant order p0,p0,p0,p0,p1,p0,...; p0_stall=1 during the p1 access.
- Priority: simultaneous single requests with wait_cnt=0 → p0 acks at N+2 and p1 acks at N+5.
- Reset mid-write: assert clr during ACCESS of a p0 write of 0xFFFFFFFF to address 10 → no ack, state IDLE. A subsequent read of address 10 returns 0.
- Stats (DM_ARB_STATS_EN defined): run the contention scenario for 10 grants → stat_p0_grants=8, stat_p1_grants=2, stat_conflicts=10.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types and constants for the data-memory port arbiter.
//   state_t : arbiter FSM states (IDLE, ACCESS, ACK)
//   owner_t : which requester owns the current access (OWN_P0, OWN_P1)
//   DM_AW / DM_DW : data memory address and data widths (64 x 32)
package dm_arb_pkg;

    localparam int DM_AW = 6;
    localparam int DM_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef enum logic {
        OWN_P0 = 1'b0,
        OWN_P1 = 1'b1
    } owner_t;

endpackage

// File: rtl/dm_arb_prio.sv
// dm_arb_prio: winner selection and starvation guard for dm_port_arbiter.
// Ports:
//   clk, clr      : clock, asynchronous active-high reset
//   p0_req        : port 0 (pipeline MEM stage) request
//   p1_req        : port 1 (debug/loader) request
//   grant_en      : high while the arbiter FSM is in IDLE and may grant
//   grant_valid   : a grant happens at the next clock edge
//   grant_owner   : winning port (OWN_P0 / OWN_P1), valid with grant_valid
//   conflict      : grant with both requests high
// Port 0 has fixed priority; once it has won MAX_WAIT times in a row while
// port 1 was waiting, port 1 is forced through.
module dm_arb_prio
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic p0_req,
    input  logic p1_req,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_owner,
    output logic conflict
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q;
    logic       force_p1;

    always_comb begin
        force_p1    = (wait_cnt_q == MAX_CNT);
        grant_valid = grant_en & (p0_req | p1_req);
        conflict    = grant_en & p0_req & p1_req;
        grant_owner = OWN_P0;
        if (p1_req && (!p0_req || force_p1)) begin
            grant_owner = OWN_P1;
        end
    end

    // Counts consecutive port 0 wins that port 1 had to sit through.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wait_cnt_q <= '0;
        end else if (grant_valid) begin
            if (grant_owner == OWN_P1) begin
                wait_cnt_q <= '0;
            end else if (p1_req) begin
                if (wait_cnt_q != MAX_CNT) begin
                    wait_cnt_q <= wait_cnt_q + 4'd1;
                end
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port 64x32 data memory between the
// pipeline MEM stage (port 0) and the debug/display/console loader (port 1).
// Each access takes IDLE (grant) -> ACCESS (memory strobe) -> ACK (pulse).
// Ports:
//   clk, clr                   : clock, asynchronous active-high reset
//   pN_req/we/addr/wdata       : request from port N, held until pN_ack
//   pN_ack, pN_rdata           : one-cycle completion pulse and read data
//   p0_stall                   : port 0 waiting (pipeline freeze)
//   dm_ra/rb/D/load/str/sel    : memory controls, active only in ACCESS
//   dm_A_out                   : combinational memory read data
// Optional: define DM_ARB_STATS_EN to add stat_p0_grants, stat_p1_grants
// and stat_conflicts (16-bit wrapping event counters).
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW       = DM_AW,
    parameter int DW       = DM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          clr,
`ifdef DM_ARB_STATS_EN
    output logic [15:0]   stat_p0_grants,
    output logic [15:0]   stat_p1_grants,
    output logic [15:0]   stat_conflicts,
`endif
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic          p0_stall,
    output logic [AW-1:0] dm_ra,
    output logic [AW-1:0] dm_rb,
    output logic [DW-1:0] dm_D,
    output logic          dm_load,
    output logic          dm_str,
    output logic          dm_sel,
    input  logic [DW-1:0] dm_A_out
);

    state_t        state_q;
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] p0_rdata_q;
    logic [DW-1:0] p1_rdata_q;
    logic          p0_ack_q;
    logic          p1_ack_q;

    logic          grant_valid;
    logic          grant_owner;
    logic          conflict;
    logic          req_we_d;
    logic [AW-1:0] req_addr_d;
    logic [DW-1:0] req_wdata_d;
    logic          in_access;

    dm_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk         (clk),
        .clr         (clr),
        .p0_req      (p0_req),
        .p1_req      (p1_req),
        .grant_en    (state_q == IDLE),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner),
        .conflict    (conflict)
    );

    // Request fields of whichever port is about to win.
    always_comb begin
        req_we_d    = p0_we;
        req_addr_d  = p0_addr;
        req_wdata_d = p0_wdata;
        if (grant_owner == OWN_P1) begin
            req_we_d    = p1_we;
            req_addr_d  = p1_addr;
            req_wdata_d = p1_wdata;
        end
    end

    // Request fields are latched only at the grant, so a requester may change
    // them after the grant without disturbing the access in flight.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            owner_q    <= OWN_P0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_owner;
                        we_q    <= req_we_d;
                        addr_q  <= req_addr_d;
                        wdata_q <= req_wdata_d;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (owner_q == OWN_P1) begin
                            p1_rdata_q <= dm_A_out;
                        end else begin
                            p0_rdata_q <= dm_A_out;
                        end
                    end
                    p0_ack_q <= (owner_q == OWN_P0);
                    p1_ack_q <= (owner_q == OWN_P1);
                    state_q  <= ACK;
                end
                ACK: begin
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory controls are only live during the single ACCESS cycle.
    always_comb begin
        in_access = (state_q == ACCESS);
        dm_sel    = in_access;
        dm_ra     = in_access ? addr_q : '0;
        dm_D      = in_access ? wdata_q : '0;
        dm_str    = in_access & we_q;
        dm_load   = in_access & ~we_q;
    end

    assign dm_rb    = dm_ra;
    assign p0_ack   = p0_ack_q;
    assign p1_ack   = p1_ack_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
    assign p0_stall = p0_req & ~p0_ack_q;

`ifdef DM_ARB_STATS_EN
    logic [15:0] stat_p0_q;
    logic [15:0] stat_p1_q;
    logic [15:0] stat_conf_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stat_p0_q   <= '0;
            stat_p1_q   <= '0;
            stat_conf_q <= '0;
        end else if (grant_valid) begin
            if (grant_owner == OWN_P1) begin
                stat_p1_q <= stat_p1_q + 16'd1;
            end else begin
                stat_p0_q <= stat_p0_q + 16'd1;
            end
            if (conflict) begin
                stat_conf_q <= stat_conf_q + 16'd1;
            end
        end
    end

    assign stat_p0_grants = stat_p0_q;
    assign stat_p1_grants = stat_p1_q;
    assign stat_conflicts = stat_conf_q;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed scoreboard bench for dm_port_arbiter.
// Holds a behavioural 64x32 memory (cleared by clr, written on dm_str) and a
// separate reference copy of what the memory should contain.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [5:0]  p0_addr = '0;
    logic [31:0] p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [5:0]  p1_addr = '0;
    logic [31:0] p1_wdata = '0;
    logic        p0_ack, p1_ack, p0_stall;
    logic [31:0] p0_rdata, p1_rdata;
    logic [5:0]  dm_ra, dm_rb;
    logic [31:0] dm_D, dm_A_out;
    logic        dm_load, dm_str, dm_sel;
`ifdef DM_ARB_STATS_EN
    logic [15:0] stat_p0_grants, stat_p1_grants, stat_conflicts;
    int          expP0G = 0, expP1G = 0, expConf = 0;
`endif

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t        sbQ[$];
    logic [31:0] memArr[64];
    logic [31:0] refMem[64];
    logic [31:0] lastRd[2];
    int          total = 0;
    int          bad = 0;

    dm_port_arbiter #(.AW(6), .DW(32), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .clr      (clr),
`ifdef DM_ARB_STATS_EN
        .stat_p0_grants (stat_p0_grants),
        .stat_p1_grants (stat_p1_grants),
        .stat_conflicts (stat_conflicts),
`endif
        .p0_req   (p0_req),
        .p0_we    (p0_we),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_ack   (p0_ack),
        .p0_rdata (p0_rdata),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_ack   (p1_ack),
        .p1_rdata (p1_rdata),
        .p0_stall (p0_stall),
        .dm_ra    (dm_ra),
        .dm_rb    (dm_rb),
        .dm_D     (dm_D),
        .dm_load  (dm_load),
        .dm_str   (dm_str),
        .dm_sel   (dm_sel),
        .dm_A_out (dm_A_out)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write at the clock edge.
    assign dm_A_out = memArr[dm_ra];
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) memArr[i] <= '0;
        end else if (dm_str) begin
            memArr[dm_ra] <= dm_D;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic req, input logic we,
                                 input logic [5:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    // Queue the expected completion of one access and update the reference.
    task automatic pushExpected(input logic port, input logic we,
                                input logic [5:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.port = port;
        if (we) begin
            refMem[addr] = wdata;
            e.data = lastRd[port];
        end else begin
            e.data = refMem[addr];
            lastRd[port] = refMem[addr];
        end
        sbQ.push_back(e);
    endtask

    task automatic popCompare(input string tag);
        exp_t        e;
        logic        obsPort;
        logic [31:0] obsData;
        if (sbQ.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sbQ.pop_front();
            obsPort = p1_ack;
            obsData = p1_ack ? p1_rdata : p0_rdata;
            checkOutput({tag, "_port"}, {31'd0, obsPort}, {31'd0, e.port});
            checkOutput({tag, "_rdata"}, obsData, e.data);
        end
    endtask

    task automatic doAccess(input logic port, input logic we, input logic [5:0] addr,
                            input logic [31:0] wdata, input string tag);
        int strCnt = 0;
        bit gotAck = 0;
        @(negedge clk);
        pushExpected(port, we, addr, wdata);
        applyStimulus(port, 1'b1, we, addr, wdata);
`ifdef DM_ARB_STATS_EN
        if (port) expP1G++; else expP0G++;
`endif
        for (int c = 0; c < 10 && !gotAck; c++) begin
            @(negedge clk);
            if (dm_str) strCnt++;
            if (port ? p1_ack : p0_ack) begin
                gotAck = 1;
                popCompare(tag);
                applyStimulus(port, 1'b0, 1'b0, 6'd0, 32'd0);
            end
        end
        applyStimulus(port, 1'b0, 1'b0, 6'd0, 32'd0);
        if (!gotAck) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        if (we) checkOutput({tag, "_str_cycles"}, strCnt, 32'd1);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) refMem[i] = '0;
        lastRd[0] = '0;
        lastRd[1] = '0;
        sbQ.delete();
`ifdef DM_ARB_STATS_EN
        expP0G = 0; expP1G = 0; expConf = 0;
`endif
    endtask

    initial begin
        int acks;
        modelReset();

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_p0_ack", p0_ack, 1'b0);
        checkOutput("rst_p1_ack", p1_ack, 1'b0);
        checkOutput("rst_dm_sel", dm_sel, 1'b0);
        checkOutput("rst_dm_ctl", {dm_load, dm_str}, 2'b00);
        checkOutput("rst_p0_rdata", p0_rdata, 32'd0);
        clr = 1'b0;

        // Single read: preload word 5 through port 1, then port 0 reads it
        doAccess(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, "preload5");
        @(negedge clk);
        pushExpected(1'b0, 1'b0, 6'd5, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd5, 32'd0);
`ifdef DM_ARB_STATS_EN
        expP0G++;
`endif
        @(negedge clk);
        checkOutput("rd_dm_load", dm_load, 1'b1);
        checkOutput("rd_dm_str", dm_str, 1'b0);
        checkOutput("rd_dm_sel", dm_sel, 1'b1);
        checkOutput("rd_dm_ra", dm_ra, 6'd5);
        checkOutput("rd_dm_rb", dm_rb, 6'd5);
        checkOutput("rd_stall", p0_stall, 1'b1);
        @(negedge clk);
        checkOutput("rd_ack", p0_ack, 1'b1);
        checkOutput("rd_ack_stall", p0_stall, 1'b0);
        checkOutput("rd_idle_ctl", {dm_sel, dm_load, dm_str}, 3'b000);
        if (p0_ack) popCompare("rd5");
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        checkOutput("rd_ack_pulse", p0_ack, 1'b0);

        // Write / readback at the top address
        doAccess(1'b1, 1'b1, 6'd63, 32'h12345678, "wr63");
        doAccess(1'b1, 1'b0, 6'd63, 32'd0, "rd63");
        doAccess(1'b0, 1'b1, 6'd7, 32'hA5A5_0F0F, "p0wr7");
        doAccess(1'b0, 1'b0, 6'd7, 32'd0, "p0rd7");

        // Contention: both ports request continuously
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            pushExpected((i == 4 || i == 9), 1'b0, (i == 4 || i == 9) ? 6'd63 : 6'd5, 32'd0);
        end
`ifdef DM_ARB_STATS_EN
        expP0G += 8; expP1G += 2; expConf += 10;
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd5, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd63, 32'd0);
        acks = 0;
        for (int c = 0; c < 60 && acks < 10; c++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                if (p1_ack) checkOutput("cont_p0_stall", p0_stall, 1'b1);
                popCompare($sformatf("cont_grant%0d", acks));
                acks++;
                if (acks == 10) begin
                    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
                    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
                end
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
        if (acks != 10) checkOutput("cont_timeout", acks, 32'd10);
        @(negedge clk);
`ifdef DM_ARB_STATS_EN
        checkOutput("stat_p0", stat_p0_grants, 16'(expP0G));
        checkOutput("stat_p1", stat_p1_grants, 16'(expP1G));
        checkOutput("stat_conf", stat_conflicts, 16'(expConf));
`endif

        // Priority: simultaneous single requests with wait_cnt cleared
        pushExpected(1'b0, 1'b0, 6'd5, 32'd0);
        pushExpected(1'b1, 1'b0, 6'd63, 32'd0);
`ifdef DM_ARB_STATS_EN
        expP0G++; expP1G++; expConf++;
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd5, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 6'd63, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("prio_p0_ack_n%0d", k), p0_ack, (k == 2));
            checkOutput($sformatf("prio_p1_ack_n%0d", k), p1_ack, (k == 5));
            if (p0_ack) begin
                popCompare("prio_p0");
                applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
            end
            if (p1_ack) begin
                popCompare("prio_p1");
                applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
`ifdef DM_ARB_STATS_EN
        checkOutput("stat_p0_prio", stat_p0_grants, 16'(expP0G));
        checkOutput("stat_conf_prio", stat_conflicts, 16'(expConf));
`endif

        // Reset in the middle of a port 0 write
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd10, 32'hFFFFFFFF);
        @(negedge clk);
        checkOutput("abort_dm_str", dm_str, 1'b1);
        checkOutput("abort_dm_ra", dm_ra, 6'd10);
        clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        modelReset();
        #1;
        checkOutput("abort_ctl_off", {dm_sel, dm_str, dm_load}, 3'b000);
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("abort_no_ack%0d", k), {p0_ack, p1_ack}, 2'b00);
        end
        doAccess(1'b0, 1'b0, 6'd10, 32'd0, "rd10_after_clr");
`ifdef DM_ARB_STATS_EN
        checkOutput("stat_p0_after_clr", stat_p0_grants, 16'(expP0G));
        checkOutput("stat_p1_after_clr", stat_p1_grants, 16'(expP1G));
`endif
        if (sbQ.size() != 0) checkOutput("sb_leftover", sbQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
